// File: rtl/umi_regif_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : umi_regif_pipe_pkg
// Purpose : UMI command codes, error encoding and helpers for the regif pipe
// Revision: 1.0
// ---------------------------------------------------------------------------
package umi_regif_pipe_pkg;

    localparam logic [4:0] c_umi_req_read   = 5'h01;
    localparam logic [4:0] c_umi_req_write  = 5'h03;
    localparam logic [4:0] c_umi_req_posted = 5'h05;
    localparam logic [4:0] c_umi_resp_read  = 5'h02;
    localparam logic [4:0] c_umi_resp_write = 5'h04;

    localparam logic [1:0] c_umi_err_ok  = 2'b00;
    localparam logic [1:0] c_umi_err_dev = 2'b10;

    localparam int c_umi_cw      = 32;
    localparam int c_umi_eom_bit = 22;
    localparam int c_umi_err_lsb = 25;

    typedef enum logic [1:0] {
        CLS_READ   = 2'd0,
        CLS_WRITE  = 2'd1,
        CLS_POSTED = 2'd2,
        CLS_ERROR  = 2'd3
    } req_class_e;

    function automatic logic umi_size_legal(input logic [2:0] size, input logic [2:0] max_size);
        return size <= max_size;
    endfunction

    // Response command word: len=0, eom=1, everything else zero.
    function automatic logic [c_umi_cw-1:0] umi_resp_cmd(input logic [4:0] opc,
                                                         input logic [2:0] size,
                                                         input logic [1:0] err);
        logic [c_umi_cw-1:0] cmd;
        cmd                        = '0;
        cmd[4:0]                   = opc;
        cmd[7:5]                   = size;
        cmd[c_umi_eom_bit]         = 1'b1;
        cmd[c_umi_err_lsb +: 2]    = err;
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/umi_regif_rspfifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : umi_regif_rspfifo
// Purpose : Single-clock response FIFO with full/empty and synchronous reset
// Revision: 1.0
// ---------------------------------------------------------------------------
module umi_regif_rspfifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wptr;
    logic [c_aw:0]    r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (c_aw+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[c_aw-1:0]] <= i_data;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                     (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign o_data  = r_mem[r_rptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: rtl/umi_regif_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : umi_regif_pipe
// Purpose : Pipelined UMI device register interface with buffered responses
// Revision: 1.0
// ---------------------------------------------------------------------------
module umi_regif_pipe
    import umi_regif_pipe_pkg::*;
#(
    parameter int AW    = 64,
    parameter int DW    = 64,
    parameter int UW    = 256,
    parameter int RL    = 1,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          udev_req_valid,
    input  logic [UW-1:0] udev_req_packet,
    output logic          udev_req_ready,
    output logic          udev_resp_valid,
    output logic [UW-1:0] udev_resp_packet,
    input  logic          udev_resp_ready,
    output logic [AW-1:0] reg_addr,
    output logic          reg_write,
    output logic          reg_read,
    output logic [7:0]    reg_cmd,
    output logic [2:0]    reg_size,
    output logic [DW-1:0] reg_wrdata,
    input  logic [DW-1:0] reg_rddata
);

    localparam int c_cw    = $clog2(DEPTH) + 1;
    localparam int c_dlsb  = 2*AW + c_umi_cw;
    localparam int c_fw    = UW - c_dlsb;
    localparam logic [2:0] c_szmax = 3'($clog2(DW/8));

    typedef struct packed {
        logic          vld;
        logic          rd;
        logic [1:0]    err;
        logic [4:0]    opc;
        logic [2:0]    size;
        logic [AW-1:0] dst;
    } meta_t;

    logic [4:0]    w_opcode;
    logic [2:0]    w_size;
    logic [7:0]    w_len;
    logic [AW-1:0] w_srcaddr;
    logic          w_ready;
    logic          w_accept;
    logic          w_need_resp;
    logic          w_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_unused_bits;
    req_class_e    w_class;
    meta_t         w_meta;
    meta_t         w_meta_out;
    logic [c_fw-1:0] w_rep;
    logic [UW-1:0] w_resp_pkt;
    logic [c_cw-1:0] r_cnt;

    assign w_opcode   = udev_req_packet[4:0];
    assign w_size     = udev_req_packet[7:5];
    assign w_len      = udev_req_packet[15:8];
    assign w_srcaddr  = udev_req_packet[2*AW+c_umi_cw-1 : AW+c_umi_cw];
    assign reg_addr   = udev_req_packet[AW+c_umi_cw-1 : c_umi_cw];
    assign reg_cmd    = udev_req_packet[7:0];
    assign reg_size   = w_size;
    assign reg_wrdata = udev_req_packet[c_dlsb +: DW];
    assign w_unused_bits = ^{udev_req_packet, w_fifo_full};

    assign w_ready        = (r_cnt < c_cw'(DEPTH)) & ~reset;
    assign udev_req_ready = w_ready;
    assign w_accept       = udev_req_valid & w_ready;

    always_comb begin
        w_class = CLS_ERROR;
        if (w_len == 8'd0 && umi_size_legal(w_size, c_szmax)) begin
            case (w_opcode)
                c_umi_req_read:   w_class = CLS_READ;
                c_umi_req_write:  w_class = CLS_WRITE;
                c_umi_req_posted: w_class = CLS_POSTED;
                default:          w_class = CLS_ERROR;
            endcase
        end
    end

    // Anything carrying the posted opcode never gets a response, legal or not.
    assign w_need_resp = w_accept & (w_opcode != c_umi_req_posted);
    assign reg_read    = w_accept & (w_class == CLS_READ);
    assign reg_write   = w_accept & ((w_class == CLS_WRITE) | (w_class == CLS_POSTED));

    always_comb begin
        w_meta      = '0;
        w_meta.vld  = w_need_resp;
        w_meta.rd   = (w_class == CLS_READ);
        w_meta.err  = (w_class == CLS_ERROR) ? c_umi_err_dev : c_umi_err_ok;
        w_meta.opc  = (w_opcode == c_umi_req_read) ? c_umi_resp_read : c_umi_resp_write;
        w_meta.size = w_size;
        w_meta.dst  = w_srcaddr;
    end

    generate
        if (RL == 0) begin : g_rl0
            assign w_meta_out = w_meta;
        end else begin : g_pipe
            meta_t r_pipe [RL];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < RL; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_meta;
                    for (int i = 1; i < RL; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_meta_out = r_pipe[RL-1];
        end
    endgenerate

    always_comb begin
        w_rep = '0;
        for (int i = 0; i < c_fw; i++) w_rep[i] = reg_rddata[i % DW];
    end

    assign w_resp_pkt = {(w_meta_out.rd ? w_rep : {c_fw{1'b0}}),
                         {AW{1'b0}},
                         w_meta_out.dst,
                         umi_resp_cmd(w_meta_out.opc, w_meta_out.size, w_meta_out.err)};

    assign udev_resp_valid = ~w_fifo_empty;
    assign w_pop           = udev_resp_valid & udev_resp_ready;

    always_ff @(posedge clk) begin
        if (reset)                          r_cnt <= '0;
        else if (w_need_resp && !w_pop)     r_cnt <= r_cnt + c_cw'(1);
        else if (!w_need_resp && w_pop)     r_cnt <= r_cnt - c_cw'(1);
    end

    umi_regif_rspfifo #(
        .WIDTH (UW),
        .DEPTH (DEPTH)
    ) u_rspfifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_meta_out.vld),
        .i_data  (w_resp_pkt),
        .i_pop   (w_pop),
        .o_data  (udev_resp_packet),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_umi_regif_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_umi_regif_pipe
// Purpose : Self-checking bench for umi_regif_pipe against a queue-based model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_umi_regif_pipe;

    localparam int AW = 64, DW = 64, UW = 256, RL = 1, DEPTH = 4;
    localparam int DLSB = 2*AW + 32;
    localparam int FW   = UW - DLSB;
    localparam int SZMAX = 3;
    localparam logic [4:0] OP_RD = 5'h01, OP_WR = 5'h03, OP_PW = 5'h05;
    localparam logic [4:0] OP_RR = 5'h02, OP_RW = 5'h04;

    logic          clk = 1'b0;
    logic          reset;
    logic          udev_req_valid;
    logic [UW-1:0] udev_req_packet;
    logic          udev_req_ready;
    logic          udev_resp_valid;
    logic [UW-1:0] udev_resp_packet;
    logic          udev_resp_ready;
    logic [AW-1:0] reg_addr;
    logic          reg_write;
    logic          reg_read;
    logic [7:0]    reg_cmd;
    logic [2:0]    reg_size;
    logic [DW-1:0] reg_wrdata;
    logic [DW-1:0] reg_rddata;

    always #5 clk = ~clk;

    umi_regif_pipe #(.AW(AW), .DW(DW), .UW(UW), .RL(RL), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .udev_req_valid   (udev_req_valid),
        .udev_req_packet  (udev_req_packet),
        .udev_req_ready   (udev_req_ready),
        .udev_resp_valid  (udev_resp_valid),
        .udev_resp_packet (udev_resp_packet),
        .udev_resp_ready  (udev_resp_ready),
        .reg_addr         (reg_addr),
        .reg_write        (reg_write),
        .reg_read         (reg_read),
        .reg_cmd          (reg_cmd),
        .reg_size         (reg_size),
        .reg_wrdata       (reg_wrdata),
        .reg_rddata       (reg_rddata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rd = 0, n_wr = 0, n_resp = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register file seen by the DUT: unwritten addresses return an address pattern.
    logic [DW-1:0] regs [logic [AW-1:0]];
    function automatic logic [DW-1:0] reg_value(input logic [AW-1:0] a);
        if (regs.exists(a)) return regs[a];
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    logic [DW-1:0] rd_sr [0:3];
    always @(posedge clk) begin
        rd_sr[0] <= reg_read ? reg_value(reg_addr) : '0;
        for (int i = 1; i < 4; i++) rd_sr[i] <= rd_sr[i-1];
    end
    assign reg_rddata = rd_sr[RL-1];

    function automatic logic [UW-1:0] mk_req(input logic [4:0] op, input logic [2:0] size,
                                             input logic [7:0] len, input logic [AW-1:0] dst,
                                             input logic [AW-1:0] src, input logic [DW-1:0] data);
        logic [UW-1:0] p;
        p = '0;
        p[31:0]              = $urandom;
        p[4:0]               = op;
        p[7:5]               = size;
        p[15:8]              = len;
        p[AW+31:32]          = dst;
        p[2*AW+31:AW+32]     = src;
        p[DLSB +: DW]        = data;
        return p;
    endfunction

    function automatic logic [UW-1:0] mk_resp(input logic [4:0] op, input logic [2:0] size,
                                              input logic [1:0] err, input logic [AW-1:0] dst,
                                              input logic [DW-1:0] rd, input bit has_data);
        logic [UW-1:0] p;
        p = '0;
        p[4:0]      = op;
        p[7:5]      = size;
        p[22]       = 1'b1;
        p[26:25]    = err;
        p[AW+31:32] = dst;
        if (has_data) for (int i = 0; i < FW; i++) p[DLSB+i] = rd[i % DW];
        return p;
    endfunction

    typedef struct { int due; logic [UW-1:0] pkt; } exp_t;
    exp_t exp_q[$];

    // Reference model and per-cycle compare.
    always @(negedge clk) begin
        logic [UW-1:0] q;
        logic [4:0] op;
        logic [2:0] sz;
        logic [7:0] ln;
        logic [AW-1:0] dst, src;
        bit exp_ready, acc, legal, rd_ok, wr_ok, pw_ok, exp_valid;
        exp_t e;

        q  = udev_req_packet;
        op = q[4:0]; sz = q[7:5]; ln = q[15:8];
        dst = q[AW+31:32]; src = q[2*AW+31:AW+32];
        exp_ready = (exp_q.size() < DEPTH) && !reset;
        chk("req_ready", udev_req_ready, exp_ready);
        chk("credit_count", dut.r_cnt, exp_q.size());
        chk("fifo_no_overflow", dut.u_rspfifo.i_push & dut.u_rspfifo.o_full, 0);

        acc   = udev_req_valid && exp_ready;
        legal = (ln == 0) && (sz <= SZMAX);
        rd_ok = acc && legal && op == OP_RD;
        wr_ok = acc && legal && op == OP_WR;
        pw_ok = acc && legal && op == OP_PW;
        chk("reg_read", reg_read, rd_ok);
        chk("reg_write", reg_write, wr_ok || pw_ok);
        if (rd_ok || wr_ok || pw_ok) begin
            chk("reg_addr", reg_addr, dst);
            chk("reg_cmd", reg_cmd, q[7:0]);
            chk("reg_size", reg_size, sz);
            chk("reg_wrdata", reg_wrdata, q[DLSB +: DW]);
        end

        if (reg_read) n_rd++;
        if (reg_write) n_wr++;
        if (!reset) begin
            exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            chk("resp_valid", udev_resp_valid, exp_valid);
            if (exp_valid) chk("resp_packet", udev_resp_packet, exp_q[0].pkt);
            if (udev_resp_valid && udev_resp_ready) begin
                n_resp++;
                if (udev_resp_packet[26:25] == 2'b10) n_err++;
            end
            if (exp_valid && udev_resp_ready) void'(exp_q.pop_front());
        end else begin
            exp_q.delete();
        end

        if (acc && op != OP_PW) begin
            e.due = cyc + RL + 1;
            e.pkt = mk_resp((op == OP_RD) ? OP_RR : OP_RW, sz,
                            (rd_ok || wr_ok) ? 2'b00 : 2'b10, src, reg_value(dst), rd_ok);
            exp_q.push_back(e);
        end
        if (wr_ok || pw_ok) regs[dst] = q[DLSB +: DW];
    end

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || udev_resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 200), 1);
    endtask

    task automatic send(input logic [UW-1:0] p);
        @(posedge clk); #1;
        udev_req_valid  = 1'b1;
        udev_req_packet = p;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        udev_req_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int drops, a0, w0, r0, e0;
        reset = 1'b1; udev_req_valid = 1'b0; udev_req_packet = '0; udev_resp_ready = 1'b0;
        regs[64'h100] = 64'h0000_0000_DEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", udev_req_ready, 0);
        chk("resp_valid_in_reset", udev_resp_valid, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", udev_req_ready, 1);

        // Single read at 0x100
        @(posedge clk); #1;
        udev_resp_ready = 1'b1;
        udev_req_valid  = 1'b1;
        udev_req_packet = mk_req(OP_RD, 3, 0, 64'h100, 64'hC0FFEE, 64'h0);
        @(negedge clk);
        chk("t1_reg_read", reg_read, 1);
        chk("t1_reg_addr", reg_addr, 64'h100);
        idle();
        @(negedge clk);
        chk("t1_resp_not_early", udev_resp_valid, 0);
        @(negedge clk);
        chk("t1_resp_valid", udev_resp_valid, 1);
        chk("t1_resp_opcode", udev_resp_packet[4:0], 5'h02);
        chk("t1_resp_dstaddr", udev_resp_packet[AW+31:32], 64'hC0FFEE);
        chk("t1_resp_data", udev_resp_packet[DLSB +: 32], 32'hDEADBEEF);
        drain("t1_drain");

        // 16 back-to-back reads
        drops = 0; r0 = n_resp;
        for (int i = 0; i < 16; i++) begin
            send(mk_req(OP_RD, 3, 0, 64'h1000 + 64'(i*8), 64'h2000 + 64'(i), 64'($urandom)));
            @(negedge clk);
            if (!udev_req_ready) drops++;
        end
        idle();
        chk("t2_ready_never_dropped", drops, 0);
        drain("t2_drain");
        chk("t2_resp_count", n_resp - r0, 16);

        // Backpressure: 6 reads offered with responses stalled
        @(posedge clk); #1 udev_resp_ready = 1'b0;
        a0 = n_rd;
        for (int i = 0; i < 6; i++) send(mk_req(OP_RD, 3, 0, 64'h3000 + 64'(i*8), 64'h3100 + 64'(i), 64'h0));
        idle();
        chk("t3_accepted", n_rd - a0, 4);
        @(negedge clk);
        chk("t3_ready_low", udev_req_ready, 0);
        repeat (3) @(posedge clk);
        #1 udev_resp_ready = 1'b1;
        @(posedge clk); #1 udev_resp_ready = 1'b0;
        @(negedge clk);
        chk("t3_ready_after_pop", udev_req_ready, 1);
        @(posedge clk); #1 udev_resp_ready = 1'b1;
        drain("t3_drain");

        // Write then posted write
        w0 = n_wr; r0 = n_resp;
        send(mk_req(OP_WR, 3, 0, 64'h20, 64'h4000, 64'h55));
        send(mk_req(OP_PW, 3, 0, 64'h24, 64'h4001, 64'hAA));
        idle();
        drain("t4_drain");
        chk("t4_write_pulses", n_wr - w0, 2);
        chk("t4_one_resp", n_resp - r0, 1);
        chk("t4_cnt_zero", dut.r_cnt, 0);
        send(mk_req(OP_RD, 3, 0, 64'h24, 64'h4002, 64'h0));
        idle();
        drain("t4_readback_drain");

        // Unsupported reads
        a0 = n_rd; e0 = n_err;
        send(mk_req(OP_RD, 3, 8'd3, 64'h40, 64'h5000, 64'h0));
        send(mk_req(OP_RD, 3'd5, 0, 64'h48, 64'h5001, 64'h0));
        idle();
        drain("t5_drain");
        chk("t5_no_reg_read", n_rd - a0, 0);
        chk("t5_err_resps", n_err - e0, 2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] op;
            logic [2:0] sz;
            logic [7:0] ln;
            @(posedge clk); #1;
            udev_resp_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0, 1:    op = OP_RD;
                2:       op = OP_WR;
                3:       op = OP_PW;
                4:       op = 5'h07;
                default: op = 5'($urandom);
            endcase
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3));
            ln = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            udev_req_valid  = ($urandom_range(0, 3) != 0);
            udev_req_packet = mk_req(op, sz, ln, 64'h80 + 64'($urandom_range(0, 15) * 8),
                                     64'($urandom), {32'($urandom), 32'($urandom)});
        end
        idle();
        @(posedge clk); #1 udev_resp_ready = 1'b1;
        drain("t6_drain");

        // Reset with three responses buffered
        @(posedge clk); #1 udev_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(mk_req(OP_RD, 3, 0, 64'h600 + 64'(i*8), 64'h700 + 64'(i), 64'h0));
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t7_buffered_valid", udev_resp_valid, 1);
        chk("t7_cnt_three", dut.r_cnt, 3);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t7_valid_cleared", udev_resp_valid, 0);
        chk("t7_cnt_cleared", dut.r_cnt, 0);
        chk("t7_ready_after_release", udev_req_ready, 1);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
